// File: rtl/iob_reg_rr_arbiter.sv
// Round-robin arbiter in front of one shared DATA_W-wide register.
// N_REQ requesters compete through a valid/ready handshake. The winner is
// registered in IDLE, and its data is written in WRITE. The search for the
// next winner starts one position after the requester served last.
// Optional feature: `define IOB_REG_RR_ARBITER_LOCK_EN adds req_lock_i. While
// the granted requester holds its lock bit, it keeps the grant and can write
// one word per cycle.
module iob_reg_rr_arbiter #(
  parameter int                N_REQ   = 4,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]        req_lock_i,
`endif
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic [IDX_W-1:0]        grant_idx_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    data_valid_o,
  output logic                    busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   last_q;
  logic [DATA_W-1:0]  data_q;
  logic               data_valid_q;

  logic               hi_found;
  logic [IDX_W-1:0]   hi_idx;
  logic [N_REQ-1:0]   hi_oh;
  logic               lo_found;
  logic [IDX_W-1:0]   lo_idx;
  logic [N_REQ-1:0]   lo_oh;
  logic               any_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [N_REQ-1:0]   win_oh;

  logic               grant_valid;
  logic [DATA_W-1:0]  grant_data;
  logic               grant_lock;

  // Wrap-around search. The lowest requester above last_q wins. If none is
  // above it, the lowest set bit overall wins, which gives the wrapped order.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    hi_oh    = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    lo_oh    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (req_valid_i[k] && !lo_found) begin
        lo_found  = 1'b1;
        lo_idx    = IDX_W'(k);
        lo_oh[k]  = 1'b1;
      end
      if (req_valid_i[k] && !hi_found && (k > 32'(last_q))) begin
        hi_found  = 1'b1;
        hi_idx    = IDX_W'(k);
        hi_oh[k]  = 1'b1;
      end
    end
    any_valid = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
    win_oh    = hi_found ? hi_oh  : lo_oh;
  end

  // Select the granted requester's valid, data and lock using the registered one-hot grant.
  always_comb begin
    grant_valid = |(grant_q & req_valid_i);
    grant_data  = '0;
    grant_lock  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        grant_data = req_data_i[k*DATA_W +: DATA_W];
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
        grant_lock = req_lock_i[k];
`endif
      end
    end
  end

  // Arbitration FSM and the shared register. Reset has priority, then clock enable.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      data_q       <= RST_VAL;
      data_valid_q <= 1'b0;
    end else if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      data_q       <= RST_VAL;
      data_valid_q <= 1'b0;
    end else if (cke_i) begin
      case (state_q)
        IDLE: begin
          data_valid_q <= 1'b0;
          if (any_valid) begin
            grant_q     <= win_oh;
            grant_idx_q <= win_idx;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (grant_valid) begin
            data_q       <= grant_data;
            last_q       <= grant_idx_q;
            data_valid_q <= 1'b1;
            if (!grant_lock) begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else begin
            // The requester withdrew valid. Abort without writing, and keep the pointer.
            data_valid_q <= 1'b0;
            state_q      <= IDLE;
            grant_q      <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifndef IOB_REG_RR_ARBITER_LOCK_EN
  // Without the lock feature, grant_lock is tied low and never keeps the FSM in WRITE.
`endif

  // Ready follows the registered grant. It is suppressed while frozen or held in reset.
  always_comb begin
    req_ready_o = '0;
    if ((state_q == WRITE) && cke_i && !rst_i)
      req_ready_o = grant_q & req_valid_i;
  end

  assign grant_o      = grant_q;
  assign grant_idx_o  = grant_idx_q;
  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = (state_q == WRITE);

endmodule

// File: tb/tb_iob_reg_rr_arbiter.sv
// Directed scoreboard bench for iob_reg_rr_arbiter (N_REQ=4, DATA_W=32).
// The lock section is built only when IOB_REG_RR_ARBITER_LOCK_EN is defined.
module tb_iob_reg_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam logic [W-1:0] RV = 32'hA5A5_0000;

  logic            clk = 1'b0;
  logic            arst;
  logic            cke;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N*W-1:0]  data;
  logic [N-1:0]    lock;
  logic [N-1:0]    ready;
  logic [N-1:0]    grant;
  logic [1:0]      gidx;
  logic [W-1:0]    dout;
  logic            dvalid;
  logic            busy;

  iob_reg_rr_arbiter #(.N_REQ(N), .DATA_W(W), .RST_VAL(RV)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .cke_i        (cke),
    .rst_i        (rst),
    .req_valid_i  (valid),
    .req_data_i   (data),
`ifdef IOB_REG_RR_ARBITER_LOCK_EN
    .req_lock_i   (lock),
`endif
    .req_ready_o  (ready),
    .grant_o      (grant),
    .grant_idx_o  (gidx),
    .data_o       (dout),
    .data_valid_o (dvalid),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned idx, input logic [W-1:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic set_data(input int unsigned k, input logic [W-1:0] val);
    data[k*W +: W] = val;
  endtask

  // Advance one clock. Outputs are sampled 1 ns after the edge, and every
  // data_valid pulse is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (dvalid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        check("sb_unexpected_pulse", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_data", 64'(dout), 64'(e.val));
        check("sb_idx", 64'(gidx), 64'(e.idx));
      end
    end
  endtask

  initial begin
    arst = 1'b1; rst = 1'b0; cke = 1'b1;
    valid = '0; data = '0; lock = '0;
    #12;
    check("arst_data", 64'(dout), 64'(RV));
    check("arst_grant", 64'(grant), 64'd0);
    check("arst_ready", 64'(ready), 64'd0);
    check("arst_dvalid", 64'(dvalid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_idx", 64'(gidx), 64'd0);
    arst = 1'b0;
    tick();

    // Single request from requester 2
    set_data(2, 32'h0000_1234);
    valid = 4'b0100;
    tick();
    check("single_grant", 64'(grant), 64'b0100);
    check("single_ready", 64'(ready), 64'b0100);
    check("single_busy", 64'(busy), 64'd1);
    check("single_dv_early", 64'(dvalid), 64'd0);
    push(2, 32'h0000_1234);
    pulses = 0;
    tick();
    valid = '0;
    check("single_pulse", 64'(pulses), 64'd1);
    check("single_idle_grant", 64'(grant), 64'd0);
    check("single_idle_busy", 64'(busy), 64'd0);

    // Synchronous reset with the clock enable low
    rst = 1'b1; cke = 1'b0;
    tick();
    check("srst_data", 64'(dout), 64'(RV));
    check("srst_dvalid", 64'(dvalid), 64'd0);
    check("srst_grant", 64'(grant), 64'd0);
    check("srst_ready", 64'(ready), 64'd0);
    check("srst_idx", 64'(gidx), 64'd0);
    rst = 1'b0; cke = 1'b1;

    // Round robin with all four requesters valid
    for (int unsigned k = 0; k < N; k++) set_data(k, 32'hC0DE_0000 + k);
    valid = 4'b1111;
    push(0, 32'hC0DE_0000);
    push(1, 32'hC0DE_0001);
    push(2, 32'hC0DE_0002);
    push(3, 32'hC0DE_0003);
    push(0, 32'hC0DE_0000);
    pulses = 0;
    for (int unsigned c = 0; c < 10; c++) tick();
    valid = '0;
    check("rr_pulses", 64'(pulses), 64'd5);
    check("rr_sb_empty", 64'(sb.size()), 64'd0);

    // Requester 1 withdraws before completion; pointer stays at 0
    set_data(1, 32'h1111_0001);
    valid = 4'b0010;
    tick();
    check("wd_grant_idx", 64'(gidx), 64'd1);
    valid = 4'b0000;
    #1;
    check("wd_ready", 64'(ready), 64'd0);
    pulses = 0;
    tick();
    check("wd_no_pulse", 64'(pulses), 64'd0);
    check("wd_data_hold", 64'(dout), 64'h0000_0000_C0DE_0000);
    check("wd_busy", 64'(busy), 64'd0);
    set_data(2, 32'h2222_0002);
    valid = 4'b0110;
    tick();
    check("wd_regrant_1", 64'(gidx), 64'd1);
    push(1, 32'h1111_0001);
    tick();
    valid = 4'b0100;
    tick();
    check("wd_then_2", 64'(gidx), 64'd2);
    push(2, 32'h2222_0002);
    tick();
    valid = '0;
    check("wd_sb_empty", 64'(sb.size()), 64'd0);

    // Clock enable dropped for three cycles while in WRITE
    set_data(1, 32'hCAFE_0001);
    valid = 4'b0010;
    tick();
    check("cke_grant", 64'(grant), 64'b0010);
    cke = 1'b0;
    #1;
    check("cke_ready_off", 64'(ready), 64'd0);
    pulses = 0;
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      check("cke_frz_ready", 64'(ready), 64'd0);
      check("cke_frz_grant", 64'(grant), 64'b0010);
      check("cke_frz_busy", 64'(busy), 64'd1);
      check("cke_frz_data", 64'(dout), 64'h0000_0000_2222_0002);
    end
    check("cke_frz_pulses", 64'(pulses), 64'd0);
    cke = 1'b1;
    #1;
    check("cke_ready_on", 64'(ready), 64'b0010);
    push(1, 32'hCAFE_0001);
    tick();
    valid = '0;
    check("cke_pulse", 64'(pulses), 64'd1);

    // Asynchronous reset in the middle of WRITE
    set_data(0, 32'h0000_DEAD);
    valid = 4'b0001;
    tick();
    check("mid_ready", 64'(ready), 64'b0001);
    #2 arst = 1'b1;
    #1;
    check("mid_ready_drop", 64'(ready), 64'd0);
    check("mid_grant", 64'(grant), 64'd0);
    check("mid_data", 64'(dout), 64'(RV));
    check("mid_busy", 64'(busy), 64'd0);
    arst = 1'b0;
    valid = '0;
    pulses = 0;
    tick();
    check("mid_no_pulse", 64'(pulses), 64'd0);

`ifdef IOB_REG_RR_ARBITER_LOCK_EN
    // Requester 3 writes three locked words back to back, then releases
    valid = 4'b1000;
    lock = 4'b1000;
    set_data(3, 32'h3333_0000);
    tick();
    check("lk_grant", 64'(grant), 64'b1000);
    pulses = 0;
    push(3, 32'h3333_0000);
    tick();
    check("lk_hold_busy", 64'(busy), 64'd1);
    set_data(3, 32'h3333_0001);
    push(3, 32'h3333_0001);
    tick();
    set_data(3, 32'h3333_0002);
    push(3, 32'h3333_0002);
    tick();
    check("lk_pulses", 64'(pulses), 64'd3);
    check("lk_grant_held", 64'(grant), 64'b1000);
    lock = '0;
    set_data(3, 32'h3333_0003);
    push(3, 32'h3333_0003);
    tick();
    check("lk_release_busy", 64'(busy), 64'd0);
    set_data(0, 32'h0000_00D0);
    valid = 4'b1001;
    tick();
    check("lk_next_winner", 64'(gidx), 64'd0);
    push(0, 32'h0000_00D0);
    tick();
    valid = '0;
    tick();
`endif

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
